// File: rtl/square_row_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : square_row_pkg
//  Description : Shared geometry defaults and width helpers for the square
//                row overlay (coordinate width, default row placement).
//  Revision    : 1.0  initial release
// ============================================================================
package square_row_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_N  = 3;
   localparam int DEF_X0 = 161;
   localparam int DEF_Y0 = 415;
   localparam int DEF_SQ = 32;

   // Index width that never collapses to zero bits (N=1 still needs a port).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/square_row_hit.sv
`default_nettype none
// ============================================================================
//  Module      : square_row_hit
//  Description : Two-stage geometry pipeline. Stage 1 registers the offsets
//                from the row origin and a range flag; stage 2 resolves the
//                square index by comparing against square starts (no divide)
//                and registers there/select/local offsets.
//  Revision    : 1.0  initial release
// ============================================================================
module square_row_hit
   import square_row_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int X0  = DEF_X0,
   parameter int Y0  = DEF_Y0,
   parameter int SQ  = DEF_SQ,
   parameter int GAP = 0
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [COORD_W-1:0]      frame_x,
   input  logic [COORD_W-1:0]      frame_y,
   output logic                    there,
   output logic [idx_w(N)-1:0]     select,
   output logic [$clog2(SQ)-1:0]   local_x,
   output logic [$clog2(SQ)-1:0]   local_y
);

   localparam int IW    = idx_w(N);
   localparam int LW    = $clog2(SQ);
   localparam int EW    = COORD_W + 2;
   localparam int PITCH = SQ + GAP;
   localparam int SPAN  = N * SQ + (N - 1) * GAP;

   localparam logic [EW-1:0] X_LO   = EW'(X0);
   localparam logic [EW-1:0] X_HI   = EW'(X0 + SPAN);
   localparam logic [EW-1:0] Y_LO   = EW'(Y0);
   localparam logic [EW-1:0] Y_HI   = EW'(Y0 + SQ);
   localparam logic [EW-1:0] SQ_LIM = EW'(SQ);

   logic [EW-1:0] fx;
   logic [EW-1:0] fy;
   logic          in_range;

   logic          s1_valid;
   logic [EW-1:0] s1_dx;
   logic [LW-1:0] s1_dy;

   logic          hit;
   logic [IW-1:0] hit_idx;
   logic [EW-1:0] start;
   logic [EW-1:0] offset;

   // Widen by two bits so X0+SPAN / Y0+SQ never wrap in the compares.
   assign fx       = {2'b00, frame_x};
   assign fy       = {2'b00, frame_y};
   assign in_range = (fx >= X_LO) && (fx < X_HI) && (fy >= Y_LO) && (fy < Y_HI);

   // Stage 1: offsets from the row origin, zeroed outside the row bounding box.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_dx    <= '0;
         s1_dy    <= '0;
      end else begin
         s1_valid <= in_range;
         s1_dx    <= in_range ? (fx - X_LO) : '0;
         s1_dy    <= in_range ? LW'(fy - Y_LO) : '0;
      end
   end

   // Pick the last square whose start is at or below dx; a remainder >= SQ is a gap.
   always_comb begin
      hit_idx = '0;
      start   = '0;
      for (int k = 1; k < N; k++) begin
         if (s1_dx >= EW'(k * PITCH)) begin
            hit_idx = IW'(k);
            start   = EW'(k * PITCH);
         end
      end
      offset = s1_dx - start;
      hit    = s1_valid && (offset < SQ_LIM);
   end

   // Stage 2: register the hit; non-hit pixels force index and offsets to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         there   <= 1'b0;
         select  <= '0;
         local_x <= '0;
         local_y <= '0;
      end else begin
         there   <= hit;
         select  <= hit ? hit_idx : '0;
         local_x <= hit ? LW'(offset) : '0;
         local_y <= hit ? s1_dy : '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/square_row_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : square_row_overlay
//  Description : Row of N squares with hit/index/offset reporting, a button
//                driven selection cursor, a frame-synchronous blinking
//                highlight of the cursor square and a confirm strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module square_row_overlay
   import square_row_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int X0    = DEF_X0,
   parameter int Y0    = DEF_Y0,
   parameter int SQ    = DEF_SQ,
   parameter int GAP   = 0,
   parameter int WRAP  = 1,
   parameter int BLINK = 16
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [COORD_W-1:0]      frame_x,
   input  logic [COORD_W-1:0]      frame_y,
   input  logic                    move_left,
   input  logic                    move_right,
   input  logic                    confirm,
   output logic                    sq_there,
   output logic [idx_w(N)-1:0]     sq_select,
   output logic [$clog2(SQ)-1:0]   sq_local_x,
   output logic [$clog2(SQ)-1:0]   sq_local_y,
   output logic                    sq_highlight,
   output logic [idx_w(N)-1:0]     cursor_idx,
   output logic                    confirm_valid,
   output logic [idx_w(N)-1:0]     confirm_idx
);

   localparam int IW = idx_w(N);
   localparam int CW = (BLINK > 1) ? $clog2(BLINK) : 1;

   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK - 1);

   logic [IW-1:0] cursor_nxt;
   logic          move_ok;
   logic [IW-1:0] disp_cursor;
   logic          at_origin;
   logic          origin_prev;
   logic          frame_start;
   logic [CW-1:0] frame_cnt;
   logic          blink_on;

   square_row_hit #(
      .N   (N),
      .X0  (X0),
      .Y0  (Y0),
      .SQ  (SQ),
      .GAP (GAP)
   ) u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .frame_x (frame_x),
      .frame_y (frame_y),
      .there   (sq_there),
      .select  (sq_select),
      .local_x (sq_local_x),
      .local_y (sq_local_y)
   );

   // Cursor step: a lone direction pulse moves; a saturated no-op is not accepted.
   always_comb begin
      cursor_nxt = cursor_idx;
      move_ok    = 1'b0;
      if (N > 1) begin
         if (move_right && !move_left) begin
            if (cursor_idx != IDX_LAST) begin
               cursor_nxt = cursor_idx + IDX_ONE;
               move_ok    = 1'b1;
            end else if (WRAP != 0) begin
               cursor_nxt = '0;
               move_ok    = 1'b1;
            end
         end else if (move_left && !move_right) begin
            if (cursor_idx != '0) begin
               cursor_nxt = cursor_idx - IDX_ONE;
               move_ok    = 1'b1;
            end else if (WRAP != 0) begin
               cursor_nxt = IDX_LAST;
               move_ok    = 1'b1;
            end
         end
      end
   end

   assign at_origin   = (frame_x == '0) && (frame_y == '0);
   assign frame_start = at_origin && !origin_prev;

   // Cursor, frame-start edge detect, displayed cursor and blink phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cursor_idx  <= '0;
         disp_cursor <= '0;
         origin_prev <= 1'b0;
         frame_cnt   <= '0;
         blink_on    <= 1'b1;
      end else begin
         cursor_idx  <= cursor_nxt;
         origin_prev <= at_origin;
         if (frame_start) begin
            disp_cursor <= cursor_idx;
         end
         if (move_ok) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
               frame_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               frame_cnt <= frame_cnt + CNT_ONE;
            end
         end
      end
   end

   // Confirm strobe one cycle later, capturing the cursor before any same-cycle move.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         confirm_valid <= 1'b0;
         confirm_idx   <= '0;
      end else begin
         confirm_valid <= confirm;
         if (confirm) begin
            confirm_idx <= cursor_idx;
         end
      end
   end

   // Highlight uses stage-2 geometry with the frame-stable displayed cursor.
   assign sq_highlight = sq_there && (sq_select == disp_cursor) && blink_on;

endmodule
`default_nettype wire

// File: tb/tb_square_row_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_square_row_overlay
//  Description : Self-checking bench. Two instances share stimulus: index 0
//                uses defaults, index 1 uses GAP=4, WRAP=0, BLINK=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_square_row_overlay;

   typedef struct packed {
      logic       t;
      logic [1:0] s;
      logic [4:0] lx;
      logic [4:0] ly;
   } geo_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] frame_x = '0;
   logic [9:0] frame_y = '0;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       confirm = 1'b0;

   logic       there[2];
   logic [1:0] sel[2];
   logic [4:0] lx[2];
   logic [4:0] ly[2];
   logic       hl[2];
   logic [1:0] cur[2];
   logic       cv[2];
   logic [1:0] ci[2];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   geo_t m_s1[2];
   geo_t m_s2[2];
   int   m_cur[2];
   int   m_disp[2];
   int   m_frames[2];
   int   m_ci[2];
   bit   m_cv[2];
   bit   m_prev00;

   always #5 clk = ~clk;

   square_row_overlay u_def (
      .clk(clk), .rst_n(rst_n), .frame_x(frame_x), .frame_y(frame_y),
      .move_left(move_left), .move_right(move_right), .confirm(confirm),
      .sq_there(there[0]), .sq_select(sel[0]), .sq_local_x(lx[0]), .sq_local_y(ly[0]),
      .sq_highlight(hl[0]), .cursor_idx(cur[0]), .confirm_valid(cv[0]), .confirm_idx(ci[0])
   );

   square_row_overlay #(.GAP(4), .WRAP(0), .BLINK(2)) u_alt (
      .clk(clk), .rst_n(rst_n), .frame_x(frame_x), .frame_y(frame_y),
      .move_left(move_left), .move_right(move_right), .confirm(confirm),
      .sq_there(there[1]), .sq_select(sel[1]), .sq_local_x(lx[1]), .sq_local_y(ly[1]),
      .sq_highlight(hl[1]), .cursor_idx(cur[1]), .confirm_valid(cv[1]), .confirm_idx(ci[1])
   );

   function automatic int gap_of(int d);   return (d == 1) ? 4 : 0;  endfunction
   function automatic bit wrap_of(int d);  return (d == 1) ? 0 : 1;  endfunction
   function automatic int blink_of(int d); return (d == 1) ? 2 : 16; endfunction

   // Geometry straight from the row definition, using divide and modulo.
   function automatic geo_t geo(int d, int x, int y);
      geo_t g = '0;
      int dx = x - 161;
      int dy = y - 415;
      int pitch = 32 + gap_of(d);
      int span = 3 * 32 + 2 * gap_of(d);
      if (dy >= 0 && dy < 32 && dx >= 0 && dx < span && (dx % pitch) < 32) begin
         g.t  = 1'b1;
         g.s  = 2'(dx / pitch);
         g.lx = 5'(dx % pitch);
         g.ly = 5'(dy);
      end
      return g;
   endfunction

   // Blink phase: solid for BLINK frames, dark for BLINK frames, counted since last clear.
   function automatic bit m_blink(int d);
      return ((m_frames[d] / blink_of(d)) % 2) == 0;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         m_s1[d] = '0; m_s2[d] = '0; m_cur[d] = 0; m_disp[d] = 0;
         m_frames[d] = 0; m_ci[d] = 0; m_cv[d] = 1'b0;
      end
      m_prev00 = 1'b0;
   endtask

   task automatic model_edge();
      bit at00;
      bit fs;
      int nc;
      if (!rst_n) begin
         model_clear();
         return;
      end
      at00 = (frame_x == 0) && (frame_y == 0);
      fs = at00 && !m_prev00;
      m_prev00 = at00;
      for (int d = 0; d < 2; d++) begin
         m_s2[d] = m_s1[d];
         m_s1[d] = geo(d, int'(frame_x), int'(frame_y));
         m_cv[d] = confirm;
         if (confirm) m_ci[d] = m_cur[d];
         nc = m_cur[d];
         if (move_right && !move_left)
            nc = (m_cur[d] == 2) ? (wrap_of(d) ? 0 : 2) : m_cur[d] + 1;
         else if (move_left && !move_right)
            nc = (m_cur[d] == 0) ? (wrap_of(d) ? 2 : 0) : m_cur[d] - 1;
         if (fs) begin
            m_disp[d] = m_cur[d];
            m_frames[d]++;
         end
         if (nc != m_cur[d]) m_frames[d] = 0;
         m_cur[d] = nc;
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(int x, int y);
      frame_x = 10'(x);
      frame_y = 10'(y);
   endtask

   task automatic test_reset();
      logic [18:0] act;
      rst_n = 1'b0;
      set_pix(170, 420);
      cyc();
      cyc();
      for (int d = 0; d < 2; d++) begin
         act = {there[d], sel[d], lx[d], ly[d], hl[d], cur[d], cv[d], ci[d]};
         n_cmp++;
         if (act !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs dut%0d: got %h want 0", d, act);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_geometry();
      int px[6] = '{161, 257, 224, 193, 193, 197};
      int py[6] = '{415, 415, 446, 447, 420, 420};
      logic [12:0] want[2][6] = '{
         '{{1'b1,2'd0,5'd0,5'd0},  {1'b0,2'd0,5'd0,5'd0},  {1'b1,2'd1,5'd31,5'd31},
           {1'b0,2'd0,5'd0,5'd0},  {1'b1,2'd1,5'd0,5'd5},  {1'b1,2'd1,5'd4,5'd5}},
         '{{1'b1,2'd0,5'd0,5'd0},  {1'b1,2'd2,5'd24,5'd0}, {1'b1,2'd1,5'd27,5'd31},
           {1'b0,2'd0,5'd0,5'd0},  {1'b0,2'd0,5'd0,5'd0},  {1'b1,2'd1,5'd0,5'd5}}};
      logic [12:0] act;
      for (int i = 0; i < 6; i++) begin
         set_pix(px[i], py[i]);
         cyc();
         cyc();
         for (int d = 0; d < 2; d++) begin
            act = {there[d], sel[d], lx[d], ly[d]};
            n_cmp++;
            if (act !== want[d][i]) begin
               n_bad++;
               $display("FAIL geometry dut%0d (%0d,%0d): got %h want %h", d, px[i], py[i], act, want[d][i]);
            end
         end
      end
   endtask

   task automatic test_cursor();
      // kind: 0 left, 1 both, 2 right
      int kind[5] = '{0, 1, 2, 2, 2};
      int want_def[5] = '{2, 2, 0, 1, 2};
      int want_alt[5] = '{0, 0, 1, 2, 2};
      for (int i = 0; i < 5; i++) begin
         move_left  = (kind[i] != 2);
         move_right = (kind[i] != 0);
         cyc();
         move_left  = 1'b0;
         move_right = 1'b0;
         n_cmp++;
         if (cur[0] !== 2'(want_def[i])) begin
            n_bad++;
            $display("FAIL cursor_wrap step%0d: got %0d want %0d", i, cur[0], want_def[i]);
         end
         n_cmp++;
         if (cur[1] !== 2'(want_alt[i])) begin
            n_bad++;
            $display("FAIL cursor_sat step%0d: got %0d want %0d", i, cur[1], want_alt[i]);
         end
      end
   endtask

   task automatic test_blink();
      bit want_alt[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      rst_n = 1'b0;
      set_pix(170, 420);
      cyc();
      rst_n = 1'b1;
      for (int f = 0; f < 6; f++) begin
         set_pix(0, 0);
         repeat (3) cyc();
         set_pix(170, 420);
         repeat (3) cyc();
         n_cmp++;
         if (hl[1] !== want_alt[f]) begin
            n_bad++;
            $display("FAIL blink_alt frame%0d: got %0b want %0b", f + 1, hl[1], want_alt[f]);
         end
         n_cmp++;
         if (hl[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL blink_def frame%0d: got %0b want 1", f + 1, hl[0]);
         end
         cyc();
      end
      // Mid-frame move: blink forced solid, displayed cursor still square 0.
      move_right = 1'b1;
      cyc();
      move_right = 1'b0;
      cyc();
      cyc();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (hl[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL move_blink dut%0d: got %0b want 1", d, hl[d]);
         end
      end
      set_pix(210, 420);
      repeat (3) cyc();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (hl[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL no_tearing dut%0d: got %0b want 0", d, hl[d]);
         end
      end
      set_pix(0, 0);
      repeat (2) cyc();
      set_pix(210, 420);
      repeat (3) cyc();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (hl[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL disp_update dut%0d: got %0b want 1", d, hl[d]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int want_ci[3]  = '{2, 1, 0};
      int want_cur[2][3] = '{'{1, 0, 2}, '{1, 0, 0}};
      rst_n = 1'b0;
      set_pix(300, 300);
      cyc();
      rst_n = 1'b1;
      move_right = 1'b1;
      cyc();
      confirm = 1'b1;
      cyc();
      confirm = 1'b0;
      move_right = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if ({cv[d], ci[d], cur[d]} !== {1'b1, 2'd1, 2'd2}) begin
            n_bad++;
            $display("FAIL confirm_move dut%0d: got v=%0b idx=%0d cur=%0d want v=1 idx=1 cur=2",
                     d, cv[d], ci[d], cur[d]);
         end
      end
      cyc();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (cv[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL confirm_single dut%0d: got %0b want 0", d, cv[d]);
         end
      end
      confirm = 1'b1;
      move_left = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({cv[d], ci[d], cur[d]} !== {1'b1, 2'(want_ci[i]), 2'(want_cur[d][i])}) begin
               n_bad++;
               $display("FAIL confirm_b2b dut%0d step%0d: got v=%0b idx=%0d cur=%0d want v=1 idx=%0d cur=%0d",
                        d, i, cv[d], ci[d], cur[d], want_ci[i], want_cur[d][i]);
            end
         end
      end
      confirm = 1'b0;
      move_left = 1'b0;
      cyc();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (cv[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL confirm_end dut%0d: got %0b want 0", d, cv[d]);
         end
      end
   endtask

   task automatic test_random();
      logic [18:0] actv;
      logic [18:0] expv;
      logic hle;
      int r;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0)      set_pix(0, 0);
         else if (r == 1) set_pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
         else             set_pix(int'($urandom_range(150, 330)), int'($urandom_range(405, 452)));
         move_left  = ($urandom_range(0, 7) == 0);
         move_right = ($urandom_range(0, 7) == 0);
         confirm    = ($urandom_range(0, 5) == 0);
         cyc();
         for (int d = 0; d < 2; d++) begin
            hle  = m_s2[d].t && (int'(m_s2[d].s) == m_disp[d]) && m_blink(d);
            actv = {there[d], sel[d], lx[d], ly[d], hl[d], cur[d], cv[d], ci[d]};
            expv = {m_s2[d].t, m_s2[d].s, m_s2[d].lx, m_s2[d].ly, hle,
                    2'(m_cur[d]), m_cv[d], 2'(m_ci[d])};
            n_cmp++;
            if (actv !== expv) begin
               n_bad++;
               $display("FAIL random dut%0d cycle%0d: got %h want %h", d, i, actv, expv);
            end
         end
      end
      move_left = 1'b0;
      move_right = 1'b0;
      confirm = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [18:0] act;
      set_pix(170, 420);
      move_right = 1'b1;
      confirm = 1'b1;
      cyc();
      move_right = 1'b0;
      confirm = 1'b0;
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         act = {there[d], sel[d], lx[d], ly[d], hl[d], cur[d], cv[d], ci[d]};
         n_cmp++;
         if (act !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_async dut%0d: got %h want 0", d, act);
         end
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (there[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flush dut%0d: got %0b want 0", d, there[d]);
         end
      end
      cyc();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if ({there[d], sel[d], lx[d], ly[d]} !== {1'b1, 2'd0, 5'd9, 5'd5}) begin
            n_bad++;
            $display("FAIL reset_resume dut%0d: got %h want %h", d,
                     {there[d], sel[d], lx[d], ly[d]}, {1'b1, 2'd0, 5'd9, 5'd5});
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      test_reset();
      test_geometry();
      test_cursor();
      test_blink();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
